// File: rtl/pht_port_sched.sv
// Port scheduler for the single-ported gshare pattern-history table.
// Shares one SRAM port between fetch lookups and retire-side 2-bit counter
// read-modify-writes, owns the global history register, and sweeps the
// table to weakly-not-taken (2'b01) after reset or flush.
//
// Handshake semantics (both request channels): a transfer happens on a
// rising edge where valid && ready are both high. ready never depends on
// valid, and a requester may hold valid high across cycles until accepted.
module pht_port_sched #(
  parameter int IDX_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             lk_v,
  input  logic [31:0]      lk_pc,
  output logic             lk_ready,
  output logic             pred_v,
  output logic             pred,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_v,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [1:0]       mem_wdata,
  input  logic [1:0]       mem_rdata,
  output logic             init_busy,
  output logic [1:0]       dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_UPD_WR = 2'd2
  } state_e;

  // Control state
  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [ST_W-1:0]  starve_q, starve_d;

  // Update FIFO
  logic [IDX_W-1:0]      fifo_idx_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_tkn_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // In-flight read-modify-write
  logic [IDX_W-1:0] rmw_idx_q, rmw_idx_d;
  logic             rmw_tkn_q, rmw_tkn_d;

  // Prediction return
  logic             pred_v_q, pred_v_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;

  // Per-cycle grant decisions
  logic             fifo_empty;
  logic             fifo_full;
  logic             starve_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_fire;
  logic             upd_pop;
  logic             upd_push;

  // PC bits outside the index window and the byte offset do not matter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};

  // 2-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
    logic [1:0] r;
    r = cnt;
    if (taken && (cnt != 2'b11)) r = cnt + 2'd1;
    else if (!taken && (cnt != 2'b00)) r = cnt - 2'd1;
    return r;
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign starve_hit = (starve_q == ST_W'(STARVE_MAX));
  assign lk_idx     = lk_pc[IDX_W+1:2] ^ ghr_q;

  assign init_busy  = (state_q == S_INIT);
  assign upd_ready  = !fifo_full && !init_busy;
  assign upd_push   = upd_v && upd_ready && !flush;

  assign pred_v     = pred_v_q;
  assign pred       = pred_v_q & mem_rdata[1];
  assign pred_idx   = pred_idx_q;
  assign dbg_state  = state_q;

  // Port arbitration, FSM next state and SRAM command generation.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    lk_ready  = 1'b0;
    lk_fire   = 1'b0;
    upd_pop   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 2'b00;

    case (state_q)
      S_INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sweep_q;
        mem_wdata = 2'b01;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Lookups own the port unless updates have waited too long.
        lk_ready = !(starve_hit && !fifo_empty) && !flush;
        if (lk_v && lk_ready) begin
          lk_fire  = 1'b1;
          mem_en   = 1'b1;
          mem_addr = lk_idx;
        end else if (!fifo_empty && !flush) begin
          upd_pop  = 1'b1;
          mem_en   = 1'b1;
          mem_addr = fifo_idx_q[rd_ptr_q];
          state_d  = S_UPD_WR;
        end
      end
      S_UPD_WR: begin
        // A flush in this cycle drops the write-back entirely.
        mem_en    = !flush;
        mem_we    = !flush;
        mem_addr  = rmw_idx_q;
        mem_wdata = sat2(mem_rdata, rmw_tkn_q);
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        sweep_d = '0;
      end
    endcase

    if (flush) begin
      state_d = S_INIT;
      sweep_d = '0;
    end

    // Keep the SRAM quiet while reset is held; the sweep starts on the
    // first edge after release.
    if (!rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Next-state for history, starvation counter, FIFO pointers and returns.
  always_comb begin
    ghr_d      = ghr_q;
    starve_d   = starve_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rmw_idx_d  = rmw_idx_q;
    rmw_tkn_d  = rmw_tkn_q;
    pred_v_d   = lk_fire;
    pred_idx_d = pred_idx_q;

    if (lk_fire) pred_idx_d = lk_idx;

    if (upd_pop) begin
      rmw_idx_d = fifo_idx_q[rd_ptr_q];
      rmw_tkn_d = fifo_tkn_q[rd_ptr_q];
    end

    if (flush) begin
      ghr_d    = '0;
      starve_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // History is architectural: it shifts at accept time, not at lookup.
      if (upd_push) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};

      if (lk_fire && !fifo_empty) starve_d = starve_q + 1'b1;
      else if (upd_pop || fifo_empty) starve_d = '0;

      if (upd_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (upd_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(upd_push) - CNT_W'(upd_pop);
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      ghr_q      <= '0;
      starve_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rmw_idx_q  <= '0;
      rmw_tkn_q  <= 1'b0;
      pred_v_q   <= 1'b0;
      pred_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      ghr_q      <= ghr_d;
      starve_q   <= starve_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rmw_idx_q  <= rmw_idx_d;
      rmw_tkn_q  <= rmw_tkn_d;
      pred_v_q   <= pred_v_d;
      pred_idx_q <= pred_idx_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (upd_push) begin
      fifo_idx_q[wr_ptr_q] <= upd_idx;
      fifo_tkn_q[wr_ptr_q] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_pht_port_sched.sv
// Bench for pht_port_sched with a 16-entry table.
module tb_pht_port_sched;

  localparam int IDX_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;

  localparam int OP_LK    = 0;
  localparam int OP_UPD   = 1;
  localparam int OP_MEM   = 2;
  localparam int OP_FLUSH = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             lk_v;
  logic [31:0]      lk_pc;
  logic             lk_ready;
  logic             pred_v;
  logic             pred;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_v;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [1:0]       mem_wdata;
  logic [1:0]       mem_rdata;
  logic             init_busy;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard of {pred, pred_idx} expected for each accepted lookup.
  logic [IDX_W:0] exp_q[$];

  typedef struct {
    int          op;
    logic [31:0] arg;
    logic        tkn;
    logic [1:0]  exp_mem;
    logic        exp_pred;
    logic [3:0]  exp_idx;
  } vec_t;
  vec_t tbl[$];

  pht_port_sched #(
    .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lk_v(lk_v), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .pred_v(pred_v), .pred(pred), .pred_idx(pred_idx),
    .upd_v(upd_v), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_busy(init_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM fixture with write logging ----------------
  logic [1:0] sram [16];
  int wr_total = 0;
  int wr3_cnt  = 0;
  int wr_idx0  = 0;
  int init_bad = 0;
  int sweep_exp = 0;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      sram[mem_addr] <= mem_wdata;
      wr_total++;
      if (mem_wdata == 2'b11) wr3_cnt++;
      if (init_busy) begin
        if (int'(mem_addr) != sweep_exp || mem_wdata != 2'b01) init_bad++;
        sweep_exp = (sweep_exp + 1) % 16;
      end else if (mem_addr == 4'd0) begin
        wr_idx0++;
      end
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr];
    end
    if (!init_busy || !rst) sweep_exp = 0;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Prediction monitor: pops the scoreboard whenever pred_v is seen.
  always @(negedge clk) begin
    if (rst && pred_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pred_v_unexpected: got pred_idx %0h with no lookup outstanding", pred_idx);
      end else begin
        chk("pred_and_idx", 32'({pred, pred_idx}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add(input int op, input logic [31:0] arg, input logic tkn,
                     input logic [1:0] em, input logic ep, input logic [3:0] ei);
    vec_t v;
    v.op = op; v.arg = arg; v.tkn = tkn; v.exp_mem = em; v.exp_pred = ep; v.exp_idx = ei;
    tbl.push_back(v);
  endtask

  task automatic wait_init();
    int n = 0;
    #1;
    while (init_busy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("init_done", 32'(init_busy), 0);
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic ep, input logic [3:0] ei);
    int n = 0;
    @(negedge clk);
    lk_v  = 1'b1;
    lk_pc = pc;
    #1;
    while (!lk_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("lookup_accepted", 32'(lk_ready), 1);
    if (lk_ready) exp_q.push_back({ep, ei});
    @(negedge clk);
    lk_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_update(input logic [3:0] idx, input logic tkn);
    int n = 0;
    @(negedge clk);
    upd_v     = 1'b1;
    upd_idx   = idx;
    upd_taken = tkn;
    #1;
    while (!upd_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("update_accepted", 32'(upd_ready), 1);
    @(negedge clk);
    upd_v = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_init();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int wt, w3, w0, low_first, low_cnt;

    rst = 1'b0; flush = 1'b0; lk_v = 1'b0; lk_pc = '0;
    upd_v = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    mem_rdata = 2'b00;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_lk_ready", 32'(lk_ready), 0);
    chk("rst_upd_ready", 32'(upd_ready), 0);
    chk("rst_init_busy", 32'(init_busy), 1);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_pred_v", 32'(pred_v), 0);
    chk("rst_pred_idx", 32'(pred_idx), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // Release and time the sweep.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sweep_first_addr", 32'(mem_addr), 0);
    chk("sweep_first_we", 32'(mem_we), 1);
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("sweep_cycles", 32'(n), 16);
    chk("sweep_writes", 32'(wr_total), 16);
    for (int i = 0; i < 16; i++) chk("sweep_value", 32'(sram[i]), 1);

    // Table: lookups, updates, memory checks and flushes.
    add(OP_LK,    32'h08, 0, 0, 0, 4'd2);
    add(OP_UPD,   5, 1, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b10, 0, 0);
    add(OP_UPD,   5, 1, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b11, 0, 0);
    add(OP_UPD,   5, 1, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b11, 0, 0);
    add(OP_LK,    32'h08, 0, 0, 1, 4'd5);
    add(OP_UPD,   5, 0, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b10, 0, 0);
    add(OP_UPD,   5, 0, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b01, 0, 0);
    add(OP_UPD,   5, 0, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b00, 0, 0);
    add(OP_UPD,   5, 0, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b00, 0, 0);
    add(OP_LK,    32'h14, 0, 0, 0, 4'd5);
    add(OP_FLUSH, 0, 0, 0, 0, 0);
    add(OP_MEM,   5, 0, 2'b01, 0, 0);
    add(OP_UPD,   9, 1, 0, 0, 0);
    add(OP_UPD,   10, 0, 0, 0, 0);
    add(OP_UPD,   11, 1, 0, 0, 0);
    add(OP_LK,    32'h14, 0, 0, 0, 4'd0);
    add(OP_LK,    32'h30, 0, 0, 1, 4'd9);
    add(OP_LK,    32'h3C, 0, 0, 0, 4'd10);
    add(OP_MEM,   9, 0, 2'b10, 0, 0);
    add(OP_MEM,   10, 0, 2'b00, 0, 0);
    add(OP_MEM,   11, 0, 2'b10, 0, 0);

    foreach (tbl[k]) begin
      case (tbl[k].op)
        OP_LK:    do_lookup(tbl[k].arg, tbl[k].exp_pred, tbl[k].exp_idx);
        OP_UPD:   do_update(tbl[k].arg[3:0], tbl[k].tkn);
        OP_MEM:   chk("table_mem", 32'(sram[tbl[k].arg[3:0]]), 32'(tbl[k].exp_mem));
        default:  do_flush();
      endcase
    end

    // Flush while a read-modify-write is in flight, one update still queued.
    w3 = wr3_cnt;
    @(negedge clk);
    upd_v = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1;
    #1;
    chk("e_upd1_ready", 32'(upd_ready), 1);
    @(negedge clk);
    upd_idx = 4'd8;
    #1;
    chk("e_rmw_read_addr", 32'(mem_addr), 9);
    chk("e_rmw_read_we", 32'(mem_we), 0);
    @(negedge clk);
    upd_v = 1'b0;
    flush = 1'b1;
    #1;
    chk("e_state_upd_wr", 32'(dbg_state), 2);
    chk("e_write_dropped", 32'(mem_we), 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("e_init_busy", 32'(init_busy), 1);
    chk("e_sweep_addr0", 32'(mem_addr), 0);
    chk("e_upd_ready_init", 32'(upd_ready), 0);
    wait_init();
    wt = wr_total;
    repeat (10) @(negedge clk);
    chk("e_fifo_emptied", 32'(wr_total - wt), 0);
    chk("e_no_rmw_write", 32'(wr3_cnt - w3), 0);
    chk("e_mem9_reinit", 32'(sram[9]), 1);
    do_lookup(32'h24, 1'b0, 4'd9);

    // Reset asserted mid-sweep at address 7.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    #1;
    while (!(init_busy && mem_addr == 4'd7) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("f_reached_addr7", 32'(mem_addr), 7);
    rst = 1'b0;
    #1;
    chk("f_init_busy", 32'(init_busy), 1);
    chk("f_lk_ready", 32'(lk_ready), 0);
    chk("f_upd_ready", 32'(upd_ready), 0);
    chk("f_mem_en", 32'(mem_en), 0);
    chk("f_mem_we", 32'(mem_we), 0);
    chk("f_pred_v", 32'(pred_v), 0);
    chk("f_pred_idx", 32'(pred_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("f_restart_addr", 32'(mem_addr), 0);
    chk("f_restart_en", 32'(mem_en), 1);
    wait_init();

    // Starvation: lookups every cycle, four not-taken updates to index 0.
    w0 = wr_idx0;
    low_first = -1;
    low_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      lk_v      = 1'b1;
      lk_pc     = $urandom();
      upd_v     = (c < 4);
      upd_idx   = 4'd0;
      upd_taken = 1'b0;
      #1;
      if (c < 4) chk("d_upd_accept", 32'(upd_ready), 1);
      if (c == 4) chk("d_full_upd_ready", 32'(upd_ready), 0);
      if (c == 9) chk("d_pop_cycle_upd_ready", 32'(upd_ready), 0);
      if (c == 10) chk("d_slot_freed", 32'(upd_ready), 1);
      if (c == 11) chk("d_lookups_resume", 32'(lk_ready), 1);
      if (lk_ready) begin
        exp_q.push_back({1'b0, lk_pc[5:2]});
      end else begin
        low_cnt++;
        if (low_first < 0) low_first = c;
      end
    end
    @(negedge clk);
    lk_v = 1'b0;
    upd_v = 1'b0;
    repeat (4) @(negedge clk);
    chk("d_first_stall", 32'(low_first), 9);
    chk("d_stall_cycles", 32'(low_cnt), 8);
    chk("d_updates_written", 32'(wr_idx0 - w0), 4);
    chk("d_mem0", 32'(sram[0]), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("sweep_order", 32'(init_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
